// File: rtl/timer_pkg.sv
// Shared types and helpers for the alarm scheduler built on the free-running timer_us counter.
package timer_pkg;

  localparam int unsigned TwDefault  = 32;
  localparam int unsigned NChDefault = 4;

  // Wrap-safe "now has reached deadline": sign of the modular difference.
  // Callers must use TW == TwDefault.
  function automatic logic time_reached(input logic [TwDefault-1:0] now,
                                        input logic [TwDefault-1:0] deadline);
    logic [TwDefault-1:0] diff;
    diff = now - deadline;
    return ~diff[TwDefault-1];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first eligible requester at or after ptr_i wins; one grant per cycle.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         mask_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  logic [N-1:0]    eligible;
  logic [IdxW-1:0] cand;

  always_comb begin
    eligible  = req_i & ~mask_i;
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % N);
      if (!valid_o && eligible[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/timer_alarm_sched.sv
// One-shot alarm channels sharing a free-running timer: round-robin arming, one shared
// comparator scanning channels, sticky expiry flags and a registered IRQ.
module timer_alarm_sched
  import timer_pkg::*;
#(
  parameter int unsigned N_CH = NChDefault,
  parameter int unsigned TW   = TwDefault
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [TW-1:0]    t_now_i,
  input  logic [N_CH-1:0]  arm_req_i,
  input  logic [N_CH*TW-1:0] arm_dur_i,
  output logic [N_CH-1:0]  arm_ack_o,
  input  logic [N_CH-1:0]  cancel_i,
  input  logic [N_CH-1:0]  clr_i,
  output logic [N_CH-1:0]  active_o,
  output logic [N_CH-1:0]  expired_o,
  output logic             irq_o
);

  localparam int unsigned IdxW = $clog2(N_CH);

  logic [N_CH-1:0] ack_q, active_q, active_d, expired_q, expired_d;
  logic [N_CH-1:0] gnt, exp_hit;
  logic [IdxW-1:0] rr_q, scan_q, gnt_idx;
  logic            gnt_valid, irq_q, reached;
  logic [TW-1:0]   deadline_q [N_CH];
  logic [TW-1:0]   dur_sel;

  // The previous cycle's ack masks its requester, which is still dropping req.
  rr_arbiter #(
    .N (N_CH)
  ) u_arb (
    .req_i     (arm_req_i),
    .mask_i    (ack_q),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (gnt_valid)
  );

  assign dur_sel = arm_dur_i[gnt_idx*TW +: TW];

  // Single shared comparator, time-multiplexed over the channels by the scan index.
  assign reached = time_reached(t_now_i, deadline_q[scan_q]);

  // Per-channel priority: arm > cancel > expire; expire beats clr.
  always_comb begin
    active_d        = active_q;
    expired_d       = expired_q;
    exp_hit         = '0;
    exp_hit[scan_q] = active_q[scan_q] & reached & ~cancel_i[scan_q] & ~gnt[scan_q];
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (gnt[k]) begin
        active_d[k]  = 1'b1;
        expired_d[k] = 1'b0;
      end else begin
        if (cancel_i[k]) active_d[k] = 1'b0;
        if (exp_hit[k]) begin
          active_d[k]  = 1'b0;
          expired_d[k] = 1'b1;
        end else if (clr_i[k]) begin
          expired_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q     <= '0;
      active_q  <= '0;
      expired_q <= '0;
      irq_q     <= 1'b0;
      rr_q      <= '0;
      scan_q    <= '0;
      for (int unsigned k = 0; k < N_CH; k++) deadline_q[k] <= '0;
    end else begin
      ack_q     <= gnt;
      active_q  <= active_d;
      expired_q <= expired_d;
      irq_q     <= |expired_d;
      scan_q    <= (scan_q == IdxW'(N_CH - 1)) ? '0 : scan_q + IdxW'(1);
      if (gnt_valid) begin
        deadline_q[gnt_idx] <= t_now_i + dur_sel;
        rr_q                <= (gnt_idx == IdxW'(N_CH - 1)) ? '0 : gnt_idx + IdxW'(1);
      end
    end
  end

  assign arm_ack_o = ack_q;
  assign active_o  = active_q;
  assign expired_o = expired_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Bench for timer_alarm_sched: vector table, hand-written corner sequences, and a random
// phase compared against a cycle-level behavioural model.
module tb_timer_alarm_sched;

  localparam int N  = 4;
  localparam int TW = 32;

  logic          clk, rst;
  logic [31:0]   t_now;
  logic [3:0]    req, ack, cancel, clr, active, expired;
  logic [127:0]  dur;
  logic          irq;

  timer_alarm_sched #(
    .N_CH (N),
    .TW   (TW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .t_now_i   (t_now),
    .arm_req_i (req),
    .arm_dur_i (dur),
    .arm_ack_o (ack),
    .cancel_i  (cancel),
    .clr_i     (clr),
    .active_o  (active),
    .expired_o (expired),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: state of each alarm as the rules describe it.
  logic [31:0] m_dl [N];
  logic [3:0]  m_act, m_exp, m_ack;
  int          m_rr, m_idx;
  logic        m_irq;

  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < N; k++) m_dl[k] = '0;
      m_act = '0; m_exp = '0; m_ack = '0; m_rr = 0; m_idx = 0; m_irq = 1'b0;
    end else begin
      logic [3:0] elig, na, ne;
      logic signed [31:0] diff;
      int g, s;
      bit hit;
      elig = req & ~m_ack;
      g = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (m_rr + i) % N;
        if (g < 0 && elig[c]) g = c;
      end
      s    = m_idx;
      diff = t_now - m_dl[s];
      hit  = m_act[s] && (diff >= 0) && (g != s) && !cancel[s];
      na = m_act;
      ne = m_exp;
      for (int k = 0; k < N; k++) begin
        if (k == g) begin
          m_dl[k] = t_now + dur[k*32 +: 32];
          na[k] = 1'b1;
          ne[k] = 1'b0;
        end else begin
          if (cancel[k]) na[k] = 1'b0;
          if (k == s && hit) begin
            na[k] = 1'b0;
            ne[k] = 1'b1;
          end else if (clr[k]) begin
            ne[k] = 1'b0;
          end
        end
      end
      m_act = na;
      m_exp = ne;
      m_ack = (g >= 0) ? 4'(1 << g) : 4'b0;
      if (g >= 0) m_rr = (g + 1) % N;
      m_idx = (m_idx + 1) % N;
      m_irq = |ne;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_scan(input int ch);
    for (int i = 0; i < N && m_idx != ch; i++) tick();
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] tnow;
    logic [3:0]  req;
    logic [31:0] dur;
    logic [3:0]  cancel;
    logic [3:0]  clr;
    logic [3:0]  e_ack;
    logic [3:0]  e_act;
    logic [3:0]  e_exp;
    bit          e_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, logic [31:0] t, logic [3:0] rq, logic [31:0] d,
                              logic [3:0] cn, logic [3:0] cl, logic [3:0] ea,
                              logic [3:0] eact, logic [3:0] eexp, bit eirq);
    vec_t v;
    v.rst = r; v.tnow = t; v.req = rq; v.dur = d; v.cancel = cn; v.clr = cl;
    v.e_ack = ea; v.e_act = eact; v.e_exp = eexp; v.e_irq = eirq;
    return v;
  endfunction

  initial begin
    bit got;

    // Arbitration: three simultaneous requests, then ch0 and ch3 with pointer at 3.
    vecs.push_back(mk(0, 32'd0, 4'b0111, 32'd1000, 4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd0, 4'b0110, 32'd1000, 4'b0, 4'b0, 4'b0010, 4'b0011, 4'b0, 0));
    vecs.push_back(mk(0, 32'd0, 4'b0100, 32'd1000, 4'b0, 4'b0, 4'b0100, 4'b0111, 4'b0, 0));
    vecs.push_back(mk(0, 32'd0, 4'b1001, 32'd1000, 4'b0, 4'b0, 4'b1000, 4'b1111, 4'b0, 0));
    vecs.push_back(mk(0, 32'd0, 4'b0001, 32'd1000, 4'b0, 4'b0, 4'b0001, 4'b1111, 4'b0, 0));
    vecs.push_back(mk(0, 32'd0, 4'b0000, 32'd1000, 4'b0, 4'b0, 4'b0000, 4'b1111, 4'b0, 0));
    // Reset with all channels armed, then time far past every old deadline.
    vecs.push_back(mk(1, 32'd5000, 4'b0, 32'd0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 32'd5000, 4'b0, 32'd0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 0));
    // Single alarm on ch0: deadline 110.
    vecs.push_back(mk(0, 32'd100, 4'b0001, 32'd10, 4'b0, 4'b0, 4'b0001, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd101, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd102, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd103, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd109, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd110, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd110, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd110, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0001, 4'b0, 0));
    vecs.push_back(mk(0, 32'd110, 4'b0000, 32'd10, 4'b0, 4'b0, 4'b0000, 4'b0000, 4'b0001, 1));
    vecs.push_back(mk(0, 32'd111, 4'b0000, 32'd10, 4'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0, 0));

    rst = 1'b0; t_now = '0; req = '0; dur = '0; cancel = '0; clr = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    check("reset state", {ack, active, expired, irq}, 13'b0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; t_now = vecs[i].tnow; req = vecs[i].req;
      dur = {4{vecs[i].dur}}; cancel = vecs[i].cancel; clr = vecs[i].clr;
      tick();
      check($sformatf("table[%0d]", i), {ack, active, expired, irq},
            {vecs[i].e_ack, vecs[i].e_act, vecs[i].e_exp, vecs[i].e_irq});
    end
    rst = 1'b0; req = '0; cancel = '0; clr = '0; dur = '0;

    // Wrap: deadline 0xFFFF_FFF0 + 0x20 = 0x10.
    t_now = 32'hFFFF_FFF0; req = 4'b0010; dur[32 +: 32] = 32'h20;
    tick();
    check("wrap arm", {ack, active}, {4'b0010, 4'b0010});
    req = '0;
    for (int i = 0; i < 31; i++) begin
      t_now = 32'hFFFF_FFF1 + 32'(i);
      tick();
      check($sformatf("wrap hold t=%0h", t_now), {active, expired}, {4'b0010, 4'b0000});
    end
    t_now = 32'h10;
    got = 0;
    for (int i = 0; i < N && !got; i++) begin
      tick();
      got = expired[1];
    end
    check("wrap expire", {got, irq, active[1]}, {1'b1, 1'b1, 1'b0});
    clr = 4'b0010;
    tick();
    clr = '0;
    check("wrap clr", {expired, irq}, 5'b0);

    // Cancel in the expiry cycle: no flag.
    t_now = 32'h100; dur = '0; req = 4'b0100;
    tick();
    check("coll arm0", ack, 4'b0100);
    req = '0;
    wait_scan(2);
    cancel = 4'b0100;
    tick();
    cancel = '0;
    check("cancel vs expire", {active[2], expired[2]}, 2'b00);
    for (int i = 0; i < N; i++) tick();
    check("cancel stays", {active[2], expired[2], irq}, 3'b000);

    // Arm and cancel together: arm wins.
    dur[64 +: 32] = 32'd50; req = 4'b0100; cancel = 4'b0100;
    tick();
    req = '0; cancel = '0;
    check("arm vs cancel", {ack, active[2]}, {4'b0100, 1'b1});
    cancel = 4'b0100;
    tick();
    cancel = '0;
    check("cancel active", active[2], 1'b0);

    // Clear and expire together: flag set.
    dur = '0; req = 4'b0100;
    tick();
    req = '0;
    wait_scan(2);
    clr = 4'b0100;
    tick();
    clr = '0;
    check("clr vs expire", {active[2], expired[2], irq}, 3'b011);
    cancel = 4'b0100;
    tick();
    cancel = '0;
    check("cancel inactive", {active[2], expired[2]}, 2'b01);
    clr = 4'b0100;
    tick();
    clr = '0;
    check("clr after expire", {expired, irq}, 5'b0);

    // dur=0 with req held through the ack cycle.
    dur = '0; req = 4'b1000;
    tick();
    check("dur0 ack", ack, 4'b1000);
    tick();
    check("ack mask", ack, 4'b0000);
    req = '0;
    got = expired[3];
    for (int i = 0; i < N - 1 && !got; i++) begin
      tick();
      got = expired[3];
    end
    check("dur0 expire", {got, active[3]}, 2'b10);

    // Req held past the ack cycle is a new arm; arm clears expired.
    dur[96 +: 32] = 32'd1000; req = 4'b1000;
    tick();
    check("rearm1", {ack, active[3], expired[3]}, {4'b1000, 1'b1, 1'b0});
    tick();
    check("rearm mask", ack, 4'b0000);
    tick();
    check("rearm2", ack, 4'b1000);
    req = '0;
    tick();
    check("rearm idle", ack, 4'b0000);
    cancel = 4'b1000;
    tick();
    cancel = '0;

    // Random phase against the model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = '0; cancel = '0; clr = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < N; k++) begin
        if (req[k] && m_ack[k]) begin
          if ($urandom_range(0, 9) != 0) req[k] = 1'b0;
        end else if (!req[k] && $urandom_range(0, 7) == 0) begin
          req[k] = 1'b1;
          dur[k*32 +: 32] = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 40);
        end
      end
      t_now  = ($urandom_range(0, 31) == 0) ? $urandom : t_now + 32'd1;
      cancel = 4'($urandom) & 4'($urandom) & 4'($urandom);
      clr    = 4'($urandom) & 4'($urandom) & 4'($urandom);
      rst    = ($urandom_range(0, 399) == 0);
      tick();
      check($sformatf("rand cycle %0d", cyc), {ack, active, expired, irq},
            {m_ack, m_act, m_exp, m_irq});
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
